branch_resolve: RTL and testbench

- Consumes resolved register operands and a branch funct3 and produces the branch decision: taken/not-taken, next PC, and misalignment/illegal flags.
- Sits between the register-read stage and PC update in the RV32I core. It is the consumer side of the operand-compare function.
- Contains its own signed/unsigned 33-bit subtract-compare.
- Uses a one-entry registered output buffer with valid/ready handshakes on both sides, plus a saturating taken-branch counter for performance monitoring.

---
 rtl/branch_resolve.sv | 151 +++++++++++++++
 tb/tb_branch_resolve.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution stage for the RV32I core.
// Takes resolved operands and a branch funct3. Produces the taken decision,
// the next PC and the misaligned/illegal flags through a one-entry output
// buffer, and keeps a saturating count of delivered taken branches.
//
// Ports:
//   clk, rstN                  clock, asynchronous active-low reset
//   flush                      synchronous drop of the buffered result
//   reqValid/reqReady          request handshake (reqReady is combinational)
//   funct3, rs1Val, rs2Val     branch type and operands
//   pc, imm                    branch address and sign-extended B-immediate
//   respValid/respReady        result handshake (respValid = buffer full)
//   taken, nextPc              branch decision and next fetch address
//   misaligned, illegal        taken target not word aligned / bad funct3
//   takenCount                 saturating count of delivered taken results
module branch_resolve #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1Val,
  input  logic [XLEN-1:0]  rs2Val,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             respValid,
  input  logic             respReady,
  output logic             taken,
  output logic [XLEN-1:0]  nextPc,
  output logic             misaligned,
  output logic             illegal,
  output logic [CNT_W-1:0] takenCount
);

  typedef struct packed {
    logic            taken;
    logic            illegal;
    logic            misaligned;
    logic [XLEN-1:0] next_pc;
  } result_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  result_t          res_q, res_d, res_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             deliver;

  // Compare and target computation for the incoming request
  logic            is_unsigned;
  logic            is_illegal;
  logic            e1, e2;
  logic [XLEN:0]   diff;
  logic            lt, eq, cond;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;

  always_comb begin
    is_illegal  = (funct3[2:1] == 2'b01);
    is_unsigned = (funct3[2:1] == 2'b11);
    // Sign-extend to XLEN+1 so one subtractor serves signed and unsigned
    e1   = is_unsigned ? 1'b0 : rs1Val[XLEN-1];
    e2   = is_unsigned ? 1'b0 : rs2Val[XLEN-1];
    diff = {e1, rs1Val} - {e2, rs2Val};
    lt   = diff[XLEN];
    eq   = (diff == '0);
    case (funct3)
      3'b000:         cond = eq;
      3'b001:         cond = ~eq;
      3'b100, 3'b110: cond = lt;
      3'b101, 3'b111: cond = ~lt;
      default:        cond = 1'b0;
    endcase
    target = pc + imm;
    seq_pc = pc + XLEN'(4);

    res_new            = '0;
    res_new.taken      = cond;
    res_new.illegal    = is_illegal;
    res_new.next_pc    = cond ? target : seq_pc;
    res_new.misaligned = cond & (target[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over any same-cycle accept
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && respReady) begin
      state_d = EMPTY;
    end
  end

  // Handshake outputs
  always_comb begin
    respValid = (state_q == FULL);
    reqReady  = ~flush & (~respValid | respReady);
    accept    = reqValid & reqReady;
    deliver   = respValid & respReady & ~flush;
  end

  // Result buffer and taken counter update
  always_comb begin
    res_d = res_q;
    if (accept) begin
      res_d = res_new;
    end
    cnt_d = cnt_q;
    if (deliver && res_q.taken && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    taken      = res_q.taken;
    illegal    = res_q.illegal;
    misaligned = res_q.misaligned;
    nextPc     = res_q.next_pc;
    takenCount = cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve: a default-width instance and a
// CNT_W=2 instance share all inputs so counter saturation is visible.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        reqValid;
  logic        respReady;
  logic [2:0]  funct3;
  logic [31:0] rs1Val, rs2Val, pc, imm;

  logic        req_ready, resp_valid, taken, misaligned, illegal;
  logic [31:0] next_pc;
  logic [15:0] taken_count;

  logic        req_ready2, resp_valid2, taken2, misaligned2, illegal2;
  logic [31:0] next_pc2;
  logic [1:0]  taken_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .reqValid(reqValid), .reqReady(req_ready),
    .funct3(funct3), .rs1Val(rs1Val), .rs2Val(rs2Val), .pc(pc), .imm(imm),
    .respValid(resp_valid), .respReady(respReady),
    .taken(taken), .nextPc(next_pc), .misaligned(misaligned),
    .illegal(illegal), .takenCount(taken_count)
  );

  branch_resolve #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rstN(rstN), .flush(flush),
    .reqValid(reqValid), .reqReady(req_ready2),
    .funct3(funct3), .rs1Val(rs1Val), .rs2Val(rs2Val), .pc(pc), .imm(imm),
    .respValid(resp_valid2), .respReady(respReady),
    .taken(taken2), .nextPc(next_pc2), .misaligned(misaligned2),
    .illegal(illegal2), .takenCount(taken_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i);
    reqValid = 1'b1;
    funct3   = f3;
    rs1Val   = a;
    rs2Val   = b;
    pc       = p;
    imm      = i;
  endtask

  task automatic check_res(input string tag, input logic v, input logic t,
                           input logic [31:0] npc, input logic mis, input logic ill);
    check({tag, ".valid"}, 32'(resp_valid), 32'(v));
    check({tag, ".taken"}, 32'(taken), 32'(t));
    check({tag, ".nextPc"}, next_pc, npc);
    check({tag, ".mis"}, 32'(misaligned), 32'(mis));
    check({tag, ".ill"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    rstN = 1'b0; flush = 1'b0; reqValid = 1'b0; respReady = 1'b0;
    funct3 = 3'b000; rs1Val = '0; rs2Val = '0; pc = '0; imm = '0;
    tick(); tick();
    check_res("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset.count", 32'(taken_count), 32'd0);
    rstN = 1'b1;

    // Back-to-back stream with the consumer always ready
    respReady = 1'b1;
    drive(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);   // BLT -1<1
    #1 check("empty.reqReady", 32'(req_ready), 32'd1);
    tick();
    check_res("blt", 1'b1, 1'b1, 32'h120, 1'b0, 1'b0);
    drive(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);   // BLTU
    tick();
    check_res("bltu", 1'b1, 1'b0, 32'h104, 1'b0, 1'b0);
    check("bltu.count", 32'(taken_count), 32'd1);
    drive(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);   // BGEU
    tick();
    check_res("bgeu", 1'b1, 1'b1, 32'h120, 1'b0, 1'b0);
    drive(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h200, 32'hFFFF_FFFE); // BEQ
    tick();
    check_res("beq", 1'b1, 1'b1, 32'h1FE, 1'b1, 1'b0);
    check("beq.count", 32'(taken_count), 32'd2);
    drive(3'b011, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h40);     // illegal
    tick();
    check_res("ill", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h500, 32'h40); // BGE min vs max
    tick();
    check_res("bge", 1'b1, 1'b0, 32'h504, 1'b0, 1'b0);
    check("bge.count", 32'(taken_count), 32'd3);
    check("bge.count2", 32'(taken_count2), 32'd3);

    // Asynchronous reset while FULL
    reqValid = 1'b0; respReady = 1'b0;
    #2 rstN = 1'b0;
    #1 check("arst.valid", 32'(resp_valid), 32'd0);
    check("arst.nextPc", next_pc, 32'h0);
    check("arst.count", 32'(taken_count), 32'd0);
    #1 rstN = 1'b1;

    // Back-pressure: BNE taken held for 3 cycles while a BEQ waits
    drive(3'b001, 32'h5, 32'h6, 32'h300, 32'h10);
    tick();
    check_res("bne", 1'b1, 1'b1, 32'h310, 1'b0, 1'b0);
    drive(3'b000, 32'h7, 32'h7, 32'h400, 32'h8);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d.reqReady", k), 32'(req_ready), 32'd0);
      tick();
      check_res($sformatf("stall%0d", k), 1'b1, 1'b1, 32'h310, 1'b0, 1'b0);
    end
    respReady = 1'b1;
    #1 check("release.reqReady", 32'(req_ready), 32'd1);
    tick();
    check_res("release", 1'b1, 1'b1, 32'h408, 1'b0, 1'b0);
    check("release.count", 32'(taken_count), 32'd1);

    // Flush with a same-cycle request while FULL
    flush = 1'b1;
    drive(3'b001, 32'h1, 32'h2, 32'h700, 32'h8);
    #1 check("flush.reqReady", 32'(req_ready), 32'd0);
    tick();
    check("flush.valid", 32'(resp_valid), 32'd0);
    check("flush.count", 32'(taken_count), 32'd1);
    flush = 1'b0;

    // Five taken deliveries: 16-bit counter goes 1->6, 2-bit saturates at 3
    for (int k = 0; k < 5; k++) begin
      drive(3'b000, 32'h1, 32'h1, 32'h600, 32'h4);
      tick();
    end
    reqValid = 1'b0;
    tick();
    check("sat.valid", 32'(resp_valid), 32'd0);
    check("sat.count", 32'(taken_count), 32'd6);
    check("sat.count2", 32'(taken_count2), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
